// File: rtl/hd_lane_tx.sv
// hd_lane_tx: 4-lane source-synchronous transmitter with a forwarded clock at clk/2.
// Define HD_TX_PARITY_EN to append one XOR-of-nibbles parity beat to each word.
`timescale 1ns/1ps
module hd_lane_tx #(
   parameter int unsigned SYNC_BEATS = 4,
   parameter logic [3:0]  SYNC_NIB   = 4'hA,
   parameter logic [3:0]  IDLE_NIB   = 4'h0,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk100,
   input  logic             rstn,
   input  logic [31:0]      s_data_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   output logic [3:0]       hd_o,
   output logic             hclk_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] word_cnt_o
);

   generate
      if (SYNC_BEATS < 1 || SYNC_BEATS > 15) begin : g_bad_sync_beats
         $error("hd_lane_tx: SYNC_BEATS must be in 1..15");
      end
   endgenerate

   localparam logic [3:0] SYNC_LAST = 4'(SYNC_BEATS - 1);

`ifdef HD_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_e;
`else
   typedef enum logic [1:0] {IDLE, SYNC, DATA} state_e;
`endif

   state_e           state_q, state_d;
   logic             ph_q;
   logic [3:0]       beat_q, beat_d;
   logic [3:0]       hd_q, hd_d;
   logic [31:0]      sh_q, sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             final_beat;
   logic             xfer;

`ifdef HD_TX_PARITY_EN
   logic [3:0] par_q, par_d;

   function automatic logic [3:0] nib_xor(input logic [31:0] w);
      logic [3:0] acc;
      acc = 4'h0;
      for (int i = 0; i < 8; i++) acc = acc ^ w[4*i +: 4];
      return acc;
   endfunction

   assign final_beat = (state_q == PAR);
`else
   assign final_beat = (state_q == DATA) && (beat_q == 4'd7);
`endif

   // Ready depends only on state and phase so the upstream can never form a combinational loop.
   assign s_ready_o  = ph_q && ((state_q == IDLE) || final_beat);
   assign xfer       = s_valid_i && s_ready_o;
   assign hd_o       = hd_q;
   assign hclk_o     = ph_q;
   assign busy_o     = (state_q != IDLE);
   assign word_cnt_o = cnt_q;

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d = state_q;
      beat_d  = beat_q;
      hd_d    = hd_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
`ifdef HD_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (xfer) cnt_d = cnt_q + CNT_W'(1);

      // Beat boundaries fall on ph 1->0; all lane-side state moves only there.
      if (ph_q) begin
         if (state_q == IDLE) begin
            if (xfer) begin
               state_d = SYNC;
               beat_d  = 4'd0;
               sh_d    = s_data_i;
               hd_d    = SYNC_NIB;
`ifdef HD_TX_PARITY_EN
               par_d   = nib_xor(s_data_i);
`endif
            end else begin
               hd_d = IDLE_NIB;
            end
         end else if (final_beat) begin
            if (xfer) begin
               state_d = DATA;
               beat_d  = 4'd0;
               hd_d    = s_data_i[31:28];
               sh_d    = {s_data_i[27:0], 4'h0};
`ifdef HD_TX_PARITY_EN
               par_d   = nib_xor(s_data_i);
`endif
            end else begin
               state_d = IDLE;
               hd_d    = IDLE_NIB;
            end
         end else begin
            case (state_q)
               SYNC: begin
                  if (beat_q == SYNC_LAST) begin
                     state_d = DATA;
                     beat_d  = 4'd0;
                     hd_d    = sh_q[31:28];
                     sh_d    = {sh_q[27:0], 4'h0};
                  end else begin
                     beat_d = beat_q + 4'd1;
                     hd_d   = SYNC_NIB;
                  end
               end
               DATA: begin
`ifdef HD_TX_PARITY_EN
                  if (beat_q == 4'd7) begin
                     state_d = PAR;
                     hd_d    = par_q;
                  end else begin
                     beat_d = beat_q + 4'd1;
                     hd_d   = sh_q[31:28];
                     sh_d   = {sh_q[27:0], 4'h0};
                  end
`else
                  beat_d = beat_q + 4'd1;
                  hd_d   = sh_q[31:28];
                  sh_d   = {sh_q[27:0], 4'h0};
`endif
               end
               default: ;
            endcase
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk100 or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         ph_q    <= 1'b0;
         beat_q  <= 4'd0;
         hd_q    <= IDLE_NIB;
         sh_q    <= 32'h0;
         cnt_q   <= '0;
`ifdef HD_TX_PARITY_EN
         par_q   <= 4'h0;
`endif
      end else begin
         state_q <= state_d;
         ph_q    <= ~ph_q;
         beat_q  <= beat_d;
         hd_q    <= hd_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
`ifdef HD_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_hd_lane_tx.sv
// tb_hd_lane_tx: directed bench for hd_lane_tx; a second instance with CNT_W=4 exercises counter wrap.
`timescale 1ns/1ps
module tb_hd_lane_tx;

   logic        clk100 = 1'b0;
   logic        rstn   = 1'b0;
   logic [31:0] s_data_i  = 32'h0;
   logic        s_valid_i = 1'b0;
   logic        s_ready_o, hclk_o, busy_o;
   logic [3:0]  hd_o;
   logic [15:0] word_cnt_o;

   logic        w_ready, w_hclk, w_busy;
   logic [3:0]  w_hd;
   logic [3:0]  w_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int xfer_cnt = 0;

   always #5 clk100 = ~clk100;

   hd_lane_tx u_dut (
      .clk100(clk100), .rstn(rstn), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
      .s_ready_o(s_ready_o), .hd_o(hd_o), .hclk_o(hclk_o), .busy_o(busy_o),
      .word_cnt_o(word_cnt_o)
   );

   hd_lane_tx #(.CNT_W(4)) u_dut_w (
      .clk100(clk100), .rstn(rstn), .s_data_i(s_data_i), .s_valid_i(s_valid_i),
      .s_ready_o(w_ready), .hd_o(w_hd), .hclk_o(w_hclk), .busy_o(w_busy),
      .word_cnt_o(w_cnt)
   );

   always @(posedge clk100) if (s_valid_i && s_ready_o) xfer_cnt <= xfer_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk100);
      #1;
   endtask

   // One beat: cycle with hclk low then cycle with hclk high, nibble held across both.
   task automatic check_beat(input string tag, input logic [3:0] nib, input logic bsy, input logic rdy);
      check({tag, ".hd0"},   {28'h0, hd_o}, {28'h0, nib});
      check({tag, ".hclk0"}, {31'h0, hclk_o}, 32'd0);
      check({tag, ".rdy0"},  {31'h0, s_ready_o}, 32'd0);
      check({tag, ".busy"},  {31'h0, busy_o}, {31'h0, bsy});
      tick();
      check({tag, ".hd1"},   {28'h0, hd_o}, {28'h0, nib});
      check({tag, ".hclk1"}, {31'h0, hclk_o}, 32'd1);
      check({tag, ".rdy1"},  {31'h0, s_ready_o}, {31'h0, rdy});
      tick();
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w, input bit with_sync,
                              input logic [3:0] par);
      logic final_rdy;
`ifdef HD_TX_PARITY_EN
      final_rdy = 1'b0;
`else
      final_rdy = 1'b1;
`endif
      if (with_sync) for (int k = 0; k < 4; k++) check_beat({tag, ".sync"}, 4'hA, 1'b1, 1'b0);
      for (int k = 0; k < 8; k++)
         check_beat({tag, ".data"}, w[31-4*k -: 4], 1'b1, (k == 7) ? final_rdy : 1'b0);
`ifdef HD_TX_PARITY_EN
      check_beat({tag, ".par"}, par, 1'b1, 1'b1);
`else
      if (par == 4'hF) $display("[TB] note: unexpected parity marker");
`endif
   endtask

   task automatic wait_ready(input string tag);
      int budget = 64;
      while (!s_ready_o && budget > 0) begin
         tick();
         budget--;
      end
      check({tag, ".ready_timeout"}, {31'h0, s_ready_o}, 32'd1);
   endtask

   task automatic send(input string tag, input logic [31:0] w);
      wait_ready(tag);
      s_data_i  = w;
      s_valid_i = 1'b1;
      tick();
      s_valid_i = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk100);
      rstn = 1'b0;
      @(negedge clk100);
      @(negedge clk100);
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int x0;
      logic exp_ph;

      // Reset state while rstn is held low
      #23;
      check("rst.hd",    {28'h0, hd_o}, 32'h0);
      check("rst.hclk",  {31'h0, hclk_o}, 32'd0);
      check("rst.ready", {31'h0, s_ready_o}, 32'd0);
      check("rst.busy",  {31'h0, busy_o}, 32'd0);
      check("rst.cnt",   {16'h0, word_cnt_o}, 32'd0);

      // Free-running forwarded clock and idle ready pulses
      @(negedge clk100);
      rstn = 1'b1;
      tick();
      exp_ph = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("idle.hclk",  {31'h0, hclk_o}, {31'h0, exp_ph});
         check("idle.ready", {31'h0, s_ready_o}, {31'h0, exp_ph});
         check("idle.hd",    {28'h0, hd_o}, 32'h0);
         tick();
         exp_ph = ~exp_ph;
      end

      // Single word
      send("w1", 32'h1234_5678);
      expect_word("w1", 32'h1234_5678, 1'b1, 4'h8);
      check_beat("w1.idle", 4'h0, 1'b0, 1'b1);
      check("w1.cnt", {16'h0, word_cnt_o}, 32'd1);

      // Back-to-back words with s_valid_i held high
      wait_ready("b2b");
      x0 = xfer_cnt;
      s_data_i  = 32'hDEAD_BEEF;
      s_valid_i = 1'b1;
      tick();
      s_data_i  = 32'h0F0F_0F0F;
      expect_word("b2b.a", 32'hDEAD_BEEF, 1'b1, 4'h0);
      s_valid_i = 1'b0;
      expect_word("b2b.b", 32'h0F0F_0F0F, 1'b0, 4'h0);
      check_beat("b2b.idle", 4'h0, 1'b0, 1'b1);
      check("b2b.xfers", xfer_cnt - x0, 32'd2);
      check("b2b.cnt", {16'h0, word_cnt_o}, 32'd3);

      // Asynchronous reset in the middle of a word
      send("mid", 32'h89AB_CDEF);
      for (int k = 0; k < 4; k++) check_beat("mid.sync", 4'hA, 1'b1, 1'b0);
      check_beat("mid.d0", 4'h8, 1'b1, 1'b0);
      check_beat("mid.d1", 4'h9, 1'b1, 1'b0);
      check_beat("mid.d2", 4'hA, 1'b1, 1'b0);
      tick();
      check("mid.pre_hd", {28'h0, hd_o}, 32'hB);
      rstn = 1'b0;
      #1;
      check("mid.hd",    {28'h0, hd_o}, 32'h0);
      check("mid.busy",  {31'h0, busy_o}, 32'd0);
      check("mid.hclk",  {31'h0, hclk_o}, 32'd0);
      check("mid.ready", {31'h0, s_ready_o}, 32'd0);
      check("mid.cnt",   {16'h0, word_cnt_o}, 32'd0);
      @(negedge clk100);
      @(negedge clk100);
      rstn = 1'b1;
      tick();
      send("post", 32'hCAFE_F00D);
      expect_word("post", 32'hCAFE_F00D, 1'b1, 4'h5);
      check_beat("post.idle", 4'h0, 1'b0, 1'b1);
      check("post.cnt", {16'h0, word_cnt_o}, 32'd1);

      // Counter wrap on the CNT_W=4 instance
      pulse_reset();
      for (int i = 1; i <= 16; i++) begin
         send("wrap", 32'h1111_1111 * i);
         check("wrap.cnt4",  {28'h0, w_cnt}, {28'h0, 4'(i)});
         check("wrap.cnt16", {16'h0, word_cnt_o}, i);
      end
      wait_ready("wrap.drain");
      tick();
      check("wrap.idle_busy", {31'h0, busy_o}, 32'd0);
      check("wrap.idle_hd",   {28'h0, hd_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hd_lane_tx.md
Name: hd_lane_tx

Overview:
Source-synchronous transmitter for the 4-lane HD link; it produces the lane data and the forwarded clock that the board receiver captures.
- Accepts 32-bit words on a valid/ready stream.
- Prepends a sync preamble to each burst.
- Serializes each word MS-nibble-first onto 4 lanes, one nibble per beat, with a forwarded clock at clk100/2.
- Sits in the PL next to the block design; its outputs go to top-level OBUFDS instances that drive HD_P/HD_N and H_CLK_P/H_CLK_N.

Parameters:
SYNC_BEATS, 4, preamble length in beats; legal range 1..15.
SYNC_NIB, 4'hA, nibble driven on every preamble beat.
IDLE_NIB, 4'h0, nibble driven when no frame is in progress.
CNT_W, 16, width of the accepted-word counter.

Ports:
clk100  input  1  sole clock; all logic on its rising edge
rstn  input  1  reset, asynchronous assert, active-low
s_data_i  input  32  word to transmit
s_valid_i  input  1  s_data_i valid
s_ready_o  output  1  block will load s_data_i this cycle
hd_o  output  4  lane data; bit i drives lane i
hclk_o  output  1  forwarded clock, free-running at clk100/2
busy_o  output  1  high while in SYNC, DATA or PAR state
word_cnt_o  output  CNT_W  count of accepted words

Behaviour:
- Reset: one clock, clk100; rstn is asynchronous, active-low. While rstn=0 all state clears immediately, independent of clk100: hd_o=IDLE_NIB, hclk_o=0, s_ready_o=0, busy_o=0, word_cnt_o=0, phase bit ph=0, state=IDLE.
- Beat timing: ph toggles every cycle after reset; one beat = 2 cycles.
  - hclk_o is registered and equals ph.
  - hclk_o runs continuously, including during IDLE.
  - hd_o updates only on the cycle where ph goes 1->0, so each nibble is stable for 2 cycles and hclk_o rises at mid-beat.
- Handshake: s_ready_o is a combinational function of state and ph only; it never depends on s_valid_i.
  - s_ready_o=1 iff ph=1 and (state=IDLE, or the current beat is the final beat of a word).
  - Transfer happens when s_valid_i && s_ready_o. s_data_i is captured into a 32-bit shift register.
  - s_valid_i without s_ready_o has no effect; the data is not consumed.
- States:
  - IDLE: hd_o=IDLE_NIB. On transfer -> SYNC, beat counter=0.
  - SYNC: hd_o=SYNC_NIB for SYNC_BEATS beats -> DATA.
  - DATA: 8 beats, hd_o = word[31:28], then [27:24], ... down to [3:0].
    - At the end of beat 8 with a transfer -> DATA again (back-to-back, no preamble).
    - At the end of beat 8 without a transfer -> IDLE.
    - With PAR enabled, beat 8 is not a final beat; the FSM always goes to PAR instead.
  - PAR: see Optional Feature.
- Latency: a transfer at end-of-beat cycle t puts the first nibble on hd_o at t+1 (SYNC_NIB from IDLE, data nibble when back-to-back).
- word_cnt_o increments by 1 on every transfer and wraps from all-ones to 0.
- Reset mid-frame: the in-flight word is dropped, outputs return to reset values, and the next word after release starts with a full preamble.
- Parameter check: SYNC_BEATS=0 is illegal and is flagged by an elaboration-time assertion.

Optional Feature:
Macro: HD_TX_PARITY_EN.
- Defined: after DATA beat 8 the FSM enters PAR for one beat.
  - hd_o = XOR of the word's 8 nibbles.
  - The end of the PAR beat is the word's final beat and acceptance point; the next state is DATA on transfer, else IDLE.
- Undefined: there is no PAR state and DATA beat 8 is the final beat.

Test Plan:
1. Reset/clock: hold rstn=0 -> hd_o=0, hclk_o=0, s_ready_o=0, word_cnt_o=0; release rstn -> hclk_o toggles every cycle (period 2), s_ready_o pulses 1 on every ph=1 cycle while idle.
2. Single word, defaults: send 0x12345678 -> 4 beats of 0xA, then 1,2,3,4,5,6,7,8, then 0x0. Each nibble lasts 2 cycles, busy_o=1 for 12 beats, word_cnt_o=1.
3. Back-to-back: s_valid_i held high with 0xDEADBEEF then 0x0F0F0F0F -> one preamble, then 16 contiguous data beats D,E,A,D,B,E,E,F,0,F,0,F,0,F,0,F. s_ready_o&&s_valid_i occurs exactly twice; word_cnt_o=2.
4. HD_TX_PARITY_EN defined: send 0x12345678 -> beat after the 8 data beats is 0x8; s_ready_o asserts only at the end of the PAR beat.
5. Reset mid-DATA: assert rstn=0 after 3 data beats -> hd_o=0 and busy_o=0 immediately (asynchronous). After release, send 0xCAFEF00D -> full 4-beat preamble, then C,A,F,E,F,0,0,D.
6. Counter wrap: CNT_W=4, send 16 words -> word_cnt_o counts 1..15 then reads 0 after the 16th transfer.
